phase_seq: RTL

- Instruction sequencer for the 16-bit multi-phase CPU.
- Drives the one-hot phase vector `ph`, the instruction register `ir` and the program counter `pc`; the execute ALU consumes all three.
- Fetches instructions through a simple request/acknowledge instruction-memory port.
- Loads branch targets back from the ALU result `alu_q`.

---
 rtl/phase_seq_if.sv | 23 ++
 rtl/phase_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/phase_seq_if.sv
// Instruction-memory request/acknowledge port of the phase sequencer.
interface phase_seq_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/phase_seq.sv
// Four-phase instruction sequencer: fetch, decode, execute, writeback.
// Define PHASE_SEQ_RETIRE_CNT_EN to build the retired-instruction counter.
module phase_seq #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RSTN,
  phase_seq_if.master      imem,
  output logic [3:0]       ph,
  output logic [15:0]      ir,
  output logic [PC_W-1:0]  pc,
  input  logic [15:0]      alu_q,
  input  logic             br_ld,
  input  logic             wb_en,
  output logic             rf_we,
  input  logic             halt,
  output logic             run,
  output logic [15:0]      retired
);

  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    PH0  = 4'b0001,
    PH1  = 4'b0010,
    PH2  = 4'b0100,
    PH3  = 4'b1000
  } phase_e;

  phase_e          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
    end
  end

  // An ack only counts in PH0, so a stray ack with no request is ignored.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: if (!halt) state_d = PH0;
      PH0: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = PH1;
        end
      end
      PH1: state_d = PH2;
      PH2: state_d = PH3;
      PH3: begin
        if (br_ld) pc_d = alu_q[PC_W-1:0];
        state_d = halt ? IDLE : PH0;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == PH0);
  end

  always_comb begin
    ph             = state_q;
    run            = (state_q != IDLE);
    rf_we          = wb_en && (state_q == PH3);
    ir             = ir_q;
    pc             = pc_q;
    imem.imem_req  = req_q;
    imem.imem_addr = pc_q;
  end

`ifdef PHASE_SEQ_RETIRE_CNT_EN
  logic [15:0] ret_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)               ret_q <= '0;
    else if (state_q == PH3) ret_q <= ret_q + 16'd1;
  end

  assign retired = ret_q;
`else
  assign retired = 16'h0000;
`endif

endmodule
